// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA raster constants (640x480 @ 60 Hz defaults)
// and the coordinate type. The generator, the renderer and the game logic
// all import this package so they agree on the raster geometry.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [DEF_CW-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Counts 0..TOTAL-1 on each adv pulse and wraps to 0. The sync and active
// flags are registered from the next count, so they always describe the
// same position as count (no skew).
// Ports:
//   clk, rst_n  : clock, async active-low reset (count resets to TOTAL-1)
//   adv         : advance enable
//   count       : current position
//   next_count  : position after the next advance
//   wrap        : count is at the last position of the axis
//   sync_n      : active-low sync for the current position
//   active      : current position is inside the visible region
module vga_axis_counter #(
    parameter int CW   = 10,
    parameter int ACT  = 640,
    parameter int FP   = 16,
    parameter int SYNC = 96,
    parameter int BP   = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    output logic [CW-1:0] count,
    output logic [CW-1:0] next_count,
    output logic          wrap,
    output logic          sync_n,
    output logic          active
);
    localparam int            TOTAL      = ACT + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(ACT + FP);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(ACT + FP + SYNC - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACT);
    // Flag values for the reset position (last position of the axis).
    localparam logic SYNC_N_RST = !((TOTAL - 1 >= ACT + FP) && (TOTAL - 1 <= ACT + FP + SYNC - 1));
    localparam logic ACTIVE_RST = (TOTAL - 1 < ACT);

    logic [CW-1:0] count_q, count_d;
    logic          sync_n_q, sync_n_d;
    logic          active_q, active_d;

    always_comb begin
        next_count = (count_q == LAST) ? '0 : count_q + 1'b1;
        count_d    = count_q;
        sync_n_d   = sync_n_q;
        active_d   = active_q;
        if (adv) begin
            count_d  = next_count;
            sync_n_d = !((next_count >= SYNC_FIRST) && (next_count <= SYNC_LAST));
            active_d = (next_count < ACT_END);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= LAST;
            sync_n_q <= SYNC_N_RST;
            active_q <= ACTIVE_RST;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
            active_q <= active_d;
        end
    end

    assign count  = count_q;
    assign wrap   = (count_q == LAST);
    assign sync_n = sync_n_q;
    assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Produces the current pixel (sx, sy), the lookahead pixel (next_x, next_y),
// active-low syncs, blank, line/frame strobes and a 16-bit frame counter.
// Reset parks the raster on the last pixel of a frame, so the first pixel
// advance after release lands on (0,0) and fires both strobes.
// Optional feature macro: VGA_TIMING_PIX_DIV_EN
//   defined   : internal /2 divider drives pix_ce (25 MHz pixels from 50 MHz)
//   undefined : pix_ce = 1, every clock is one pixel
// Ports:
//   CLOCK_50, rst_n      : clock, async active-low reset
//   pix_ce               : pixel-advance enable
//   sx, sy               : current pixel coordinate
//   next_x, next_y       : coordinate after the next pixel advance
//   VGA_HS, VGA_VS       : active-low syncs
//   VGA_BLANK_N          : high inside the visible area
//   VGA_SYNC_N           : tied low
//   line_start           : one-clock strobe on entering x=0
//   frame_start          : one-clock strobe on entering (0,0)
//   frame_cnt            : frames started since reset
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CW       = DEF_CW
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    output logic          pix_ce,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic [CW-1:0] next_x,
    output logic [CW-1:0] next_y,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);
    logic [CW-1:0] h_next, v_next;
    logic          h_wrap, v_wrap;
    logic          h_sync_n, v_sync_n;
    logic          h_active, v_active;

`ifdef VGA_TIMING_PIX_DIV_EN
    logic pix_ce_q, pix_ce_d;

    always_comb pix_ce_d = !pix_ce_q;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) pix_ce_q <= 1'b0;
        else        pix_ce_q <= pix_ce_d;
    end

    assign pix_ce = pix_ce_q;
`else
    assign pix_ce = 1'b1;
`endif

    vga_axis_counter #(
        .CW(CW), .ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk(CLOCK_50), .rst_n(rst_n), .adv(pix_ce),
        .count(sx), .next_count(h_next), .wrap(h_wrap),
        .sync_n(h_sync_n), .active(h_active)
    );

    // Vertical axis steps once per line, on the horizontal wrap.
    vga_axis_counter #(
        .CW(CW), .ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk(CLOCK_50), .rst_n(rst_n), .adv(pix_ce & h_wrap),
        .count(sy), .next_count(v_next), .wrap(v_wrap),
        .sync_n(v_sync_n), .active(v_active)
    );

    assign next_x = h_next;
    assign next_y = h_wrap ? v_next : sy;

    // Strobes are registered every clock (not gated by pix_ce) so they
    // last exactly one CLOCK_50 cycle even when the divider is built in.
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        line_start_d  = pix_ce & h_wrap;
        frame_start_d = pix_ce & h_wrap & v_wrap;
        frame_cnt_d   = frame_cnt_q;
        if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign VGA_HS      = h_sync_n;
    assign VGA_VS      = v_sync_n;
    assign VGA_BLANK_N = h_active & v_active;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen (divider not built).
// Two instances share clock and reset: "d_" uses the default 640x480
// timing, "s_" uses a tiny 16x11 raster so whole frames fit in a short run.
// Small raster: H 8/2/3/3 (HS low at sx 10..12), V 6/1/2/2 (VS low at sy 7..8).
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        d_ce, d_hs, d_vs, d_bl, d_sn, d_ls, d_fs;
    logic [9:0]  d_sx, d_sy, d_nx, d_ny;
    logic [15:0] d_fc;
    logic        s_ce, s_hs, s_vs, s_bl, s_sn, s_ls, s_fs;
    logic [9:0]  s_sx, s_sy, s_nx, s_ny;
    logic [15:0] s_fc;

    vga_timing_gen dut (
        .CLOCK_50(clk), .rst_n(rst_n), .pix_ce(d_ce), .sx(d_sx), .sy(d_sy),
        .next_x(d_nx), .next_y(d_ny), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sn), .line_start(d_ls),
        .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .CW(10)
    ) dut_s (
        .CLOCK_50(clk), .rst_n(rst_n), .pix_ce(s_ce), .sx(s_sx), .sy(s_sy),
        .next_x(s_nx), .next_y(s_ny), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn), .line_start(s_ls),
        .frame_start(s_fs), .frame_cnt(s_fc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int dx, dy, dnx, dny, sxm, sym, snx, sny;
        int d_coord_err, d_next_err, d_ls_err, d_fs_err, d_bl_err;
        int s_coord_err, s_next_err, s_fs_err, s_bl_err, s_fs_cnt, s_fc_at2;
        int hs_low, hs_first, bl_fall, d_ls_cnt, vs_low, vs_first_x, vs_first_y;
        int s_n5x, s_n5y, s_n10x, s_n10y, d_n0x, d_n0y;
        d_coord_err = 0; d_next_err = 0; d_ls_err = 0; d_fs_err = 0; d_bl_err = 0;
        s_coord_err = 0; s_next_err = 0; s_fs_err = 0; s_bl_err = 0;
        s_fs_cnt = 0; s_fc_at2 = -1; hs_low = 0; hs_first = -1; bl_fall = -1;
        d_ls_cnt = 0; vs_low = 0; vs_first_x = -1; vs_first_y = -1;
        s_n5x = -1; s_n5y = -1; s_n10x = -1; s_n10y = -1; d_n0x = -1; d_n0y = -1;

        // Reset state: last pixel of a frame.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sx", d_sx, 799);
        check("rst_sy", d_sy, 524);
        check("rst_hs", d_hs, 1);
        check("rst_vs", d_vs, 1);
        check("rst_blank", d_bl, 0);
        check("rst_next_x", d_nx, 0);
        check("rst_next_y", d_ny, 0);
        check("rst_line_start", d_ls, 0);
        check("rst_frame_start", d_fs, 0);
        check("rst_frame_cnt", d_fc, 0);
        check("sync_n_const", d_sn, 0);
        check("pix_ce_const", d_ce, 1);
        check("s_rst_sx", s_sx, 15);
        check("s_rst_sy", s_sy, 10);

        // First advance lands on (0,0) with both strobes.
        rst_n = 1'b1;
        @(negedge clk);
        check("first_sx", d_sx, 0);
        check("first_sy", d_sy, 0);
        check("first_frame_start", d_fs, 1);
        check("first_line_start", d_ls, 1);
        check("first_blank", d_bl, 1);
        check("first_frame_cnt", d_fc, 1);
        check("s_first_frame_start", s_fs, 1);
        check("s_first_frame_cnt", s_fc, 1);

        // Two full default lines; ~9 small frames.
        for (int k = 1; k <= 1600; k++) begin
            @(negedge clk);
            dx = k % 800; dy = k / 800;
            dnx = (dx == 799) ? 0 : dx + 1;
            dny = (dx == 799) ? dy + 1 : dy;
            if (d_sx !== 10'(dx) || d_sy !== 10'(dy)) d_coord_err++;
            if (d_nx !== 10'(dnx) || d_ny !== 10'(dny)) d_next_err++;
            if (d_ls !== (dx == 0)) d_ls_err++;
            if (d_fs !== 1'b0) d_fs_err++;
            if (d_bl !== (dx < 640 && dy < 480)) d_bl_err++;
            if (d_ls === 1'b1) d_ls_cnt++;
            if (dy == 1) begin
                if (d_hs === 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = dx;
                end
                if (d_bl === 1'b0 && bl_fall < 0) bl_fall = dx;
            end
            if (dx == 799 && dy == 0) begin d_n0x = d_nx; d_n0y = d_ny; end

            sxm = k % 16; sym = (k / 16) % 11;
            snx = (sxm == 15) ? 0 : sxm + 1;
            sny = (sxm == 15) ? ((sym == 10) ? 0 : sym + 1) : sym;
            if (s_sx !== 10'(sxm) || s_sy !== 10'(sym)) s_coord_err++;
            if (s_nx !== 10'(snx) || s_ny !== 10'(sny)) s_next_err++;
            if (s_fs !== (sxm == 0 && sym == 0)) s_fs_err++;
            if (s_bl !== (sxm < 8 && sym < 6)) s_bl_err++;
            if (s_fs === 1'b1) begin
                s_fs_cnt++;
                if (s_fs_cnt == 1) s_fc_at2 = s_fc;
            end
            if (k < 176 && s_vs === 1'b0) begin
                vs_low++;
                if (vs_first_x < 0) begin vs_first_x = sxm; vs_first_y = sym; end
            end
            if (sxm == 15 && sym == 5)  begin s_n5x = s_nx;  s_n5y = s_ny;  end
            if (sxm == 15 && sym == 10) begin s_n10x = s_nx; s_n10y = s_ny; end
        end

        check("d_coord_mismatches", d_coord_err, 0);
        check("d_next_mismatches", d_next_err, 0);
        check("d_line_start_mismatches", d_ls_err, 0);
        check("d_frame_start_spurious", d_fs_err, 0);
        check("d_blank_mismatches", d_bl_err, 0);
        check("d_line_start_pulses", d_ls_cnt, 2);
        check("hs_low_width", hs_low, 96);
        check("hs_low_first_sx", hs_first, 656);
        check("blank_fall_sx", bl_fall, 640);
        check("d_next_x_at_799_0", d_n0x, 0);
        check("d_next_y_at_799_0", d_n0y, 1);
        check("s_coord_mismatches", s_coord_err, 0);
        check("s_next_mismatches", s_next_err, 0);
        check("s_frame_start_mismatches", s_fs_err, 0);
        check("s_blank_mismatches", s_bl_err, 0);
        check("s_frame_start_pulses", s_fs_cnt, 9);
        check("s_frame_cnt_second_frame", s_fc_at2, 2);
        check("s_frame_cnt_end", s_fc, 10);
        check("s_vs_low_width", vs_low, 32);
        check("s_vs_first_x", vs_first_x, 0);
        check("s_vs_first_y", vs_first_y, 7);
        check("s_next_x_at_last_x_mid", s_n5x, 0);
        check("s_next_y_at_last_x_mid", s_n5y, 6);
        check("s_next_x_at_last_pixel", s_n10x, 0);
        check("s_next_y_at_last_pixel", s_n10y, 0);

        // Move to (320,2), then reset between edges.
        repeat (320) @(negedge clk);
        check("mid_sx", d_sx, 320);
        check("mid_sy", d_sy, 2);
        check("mid_blank", d_bl, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sx", d_sx, 799);
        check("async_rst_sy", d_sy, 524);
        check("async_rst_hs", d_hs, 1);
        check("async_rst_vs", d_vs, 1);
        check("async_rst_blank", d_bl, 0);
        check("async_rst_frame_cnt", d_fc, 0);
        check("s_async_rst_frame_cnt", s_fc, 0);
        check("s_async_rst_sx", s_sx, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
